// File: rtl/range_rand_pkg.sv
// range_rand_pkg
// Shared types and constants for the bounded random number generator.
//   status_e : response status codes carried on resp_status
//   state_e  : control FSM states of range_rand_gen
//   TAPS_16 / TAPS_32 : Galois feedback masks for the supported LFSR widths
//   lfsr_taps() : picks the feedback mask for a given LFSR width
package range_rand_pkg;

   typedef enum logic [1:0] {
      ST_OK           = 2'd0,
      ST_BELOW_THRESH = 2'd1,
      ST_RANGE_ERR    = 2'd2,
      ST_FALLBACK     = 2'd3
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [31:0] TAPS_32 = 32'h80200003;

   // Returns the feedback mask right-aligned in 32 bits; callers slice to width.
   function automatic logic [31:0] lfsr_taps(input int unsigned w);
      return (w == 32) ? TAPS_32 : {16'h0000, TAPS_16};
   endfunction

endpackage

// File: rtl/range_rand_gen_lfsr.sv
// lfsr_galois
// Right-shifting Galois LFSR that advances only when enabled.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, loads SEED (0 is replaced by 1)
//   enable : advance one step this cycle
//   value  : current generator state
module lfsr_galois #(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic [WIDTH-1:0] value
);

   // An all-zero state would lock the generator, so a zero seed becomes 1.
   localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

   // Shift right; when the bit falling out is 1, fold the feedback mask in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= SEED_NZ;
      end else if (enable) begin
         if (value[0]) begin
            value <= (value >> 1) ^ TAPS;
         end else begin
            value <= value >> 1;
         end
      end
   end

endmodule

// File: rtl/range_rand_gen.sv
// range_rand_gen
// Returns a pseudo-random value in [req_lo, req_hi] by masked rejection
// sampling from a Galois LFSR, with threshold / range-error short paths and a
// fallback to req_lo after MAX_TRIES rejected draws.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake, bounds on req_lo/req_hi
//   resp_valid/resp_ready : response handshake
//   resp_data           : result value
//   resp_status         : OK=0, BELOW_THRESH=1, RANGE_ERR=2, FALLBACK=3
//   resp_tries          : number of draws spent on this result
// Optional build macro: RANGE_RAND_GEN_ASSERT_EN compiles in runtime assertions.
module range_rand_gen
   import range_rand_pkg::*;
#(
   parameter int unsigned       WIDTH     = 8,
   parameter int unsigned       LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
   parameter int unsigned       THRESH    = 10,
   parameter int unsigned       MAX_TRIES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_lo,
   input  logic [WIDTH-1:0] req_hi,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic [1:0]       resp_status,
   output logic [7:0]       resp_tries
);

   localparam logic [31:0]       TAPS_FULL = lfsr_taps(LFSR_W);
   localparam logic [LFSR_W-1:0] TAPS      = TAPS_FULL[LFSR_W-1:0];

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  lo_q, lo_d, hi_q, hi_d;
   logic [7:0]        cnt_q, cnt_d, cnt_inc;
   logic [WIDTH-1:0]  data_q, data_d;
   status_e           status_q, status_d;
   logic [7:0]        tries_q, tries_d;

   logic [LFSR_W-1:0] lfsr_value;
   logic              lfsr_en;
   logic [WIDTH-1:0]  span, mask, cand;
   logic              unused_lfsr_bits;

   // The generator steps only while a draw is being evaluated, so results
   // depend solely on how many draws have been made since reset.
   assign lfsr_en = (state_q == S_DRAW);

   lfsr_galois #(
      .WIDTH (LFSR_W),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .enable (lfsr_en),
      .value  (lfsr_value)
   );

   // Only the low WIDTH generator bits feed draws; the rest are sunk here.
   assign unused_lfsr_bits = ^lfsr_value;

   // Mask is the smallest all-ones pattern covering span, so a candidate is
   // rejected with probability below one half.
   always_comb begin
      span = hi_q - lo_q;
      mask = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         mask[i] = |(span >> i);
      end
      cand = lfsr_value[WIDTH-1:0] & mask;
   end

   assign cnt_inc     = cnt_q + 8'd1;
   assign req_ready   = (state_q == S_IDLE) && !rst;
   assign resp_valid  = (state_q == S_RESP);
   assign resp_data   = data_q;
   assign resp_status = status_q;
   assign resp_tries  = tries_q;

   // Next-state and payload logic. Short paths (threshold, bad range) go
   // straight to RESP; valid ranges draw until a candidate fits or the try
   // budget runs out.
   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      status_d = status_q;
      tries_d  = tries_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               lo_d  = req_lo;
               hi_d  = req_hi;
               cnt_d = 8'd0;
               if (32'(req_lo) <= THRESH) begin
                  state_d  = S_RESP;
                  data_d   = '0;
                  status_d = ST_BELOW_THRESH;
                  tries_d  = 8'd0;
               end else if (req_lo > req_hi) begin
                  state_d  = S_RESP;
                  data_d   = '0;
                  status_d = ST_RANGE_ERR;
                  tries_d  = 8'd0;
               end else begin
                  state_d = S_DRAW;
               end
            end
         end
         S_DRAW: begin
            if (cand <= span) begin
               state_d  = S_RESP;
               data_d   = lo_q + cand;
               status_d = ST_OK;
               tries_d  = cnt_inc;
            end else if (cnt_inc == 8'(MAX_TRIES)) begin
               state_d  = S_RESP;
               data_d   = lo_q;
               status_d = ST_FALLBACK;
               tries_d  = cnt_inc;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and payload registers; reset drops any request in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         lo_q     <= '0;
         hi_q     <= '0;
         cnt_q    <= 8'd0;
         data_q   <= '0;
         status_q <= ST_OK;
         tries_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         status_q <= status_d;
         tries_q  <= tries_d;
      end
   end

`ifdef RANGE_RAND_GEN_ASSERT_EN
   // Successful and fallback results always lie inside the requested bounds.
   a_result_in_range: assert property (@(posedge clk) disable iff (rst)
      (resp_valid && (status_q == ST_OK || status_q == ST_FALLBACK))
         |-> (resp_data >= lo_q && resp_data <= hi_q))
      else $error("range_rand_gen: result outside requested bounds");

   // Error-type results carry a zero payload.
   a_error_data_zero: assert property (@(posedge clk) disable iff (rst)
      (resp_valid && (status_q == ST_RANGE_ERR || status_q == ST_BELOW_THRESH))
         |-> (resp_data == '0))
      else $error("range_rand_gen: error status with nonzero data");

   // A stalled response must not change under the consumer.
   a_payload_stable: assert property (@(posedge clk) disable iff (rst)
      (resp_valid && !resp_ready)
         |=> (resp_valid && $stable(resp_data) && $stable(resp_status)
              && $stable(resp_tries)))
      else $error("range_rand_gen: response payload changed while stalled");

   // The generator must never reach its lock-up state.
   a_lfsr_nonzero: assert property (@(posedge clk) disable iff (rst)
      (lfsr_value != '0))
      else $error("range_rand_gen: LFSR reached zero");
`endif

endmodule

// File: doc/range_rand_gen.md
RANGE_RAND_GEN -- requirements
Module: range_rand_gen

Interface
REQ-001 Parameter WIDTH, 8, bit width of bounds and result (2..32).
REQ-002 Parameter LFSR_W, 16, LFSR width (16 or 32; WIDTH <= LFSR_W).
REQ-003 Parameter SEED, 16'hACE1, LFSR reset value; a value of 0 SHALL be replaced by 1.
REQ-004 Parameter THRESH, 10, lower-bound threshold; lo <= THRESH yields result 0.
REQ-005 Parameter MAX_TRIES, 8, rejected draws before fallback (1..255).
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block accepts request.
REQ-010 req_lo  input  WIDTH  inclusive lower bound.
REQ-011 req_hi  input  WIDTH  inclusive upper bound.
REQ-012 resp_valid  output  1  result present.
REQ-013 resp_ready  input  1  consumer takes result.
REQ-014 resp_data  output  WIDTH  result value.
REQ-015 resp_status  output  2  OK=0, BELOW_THRESH=1, RANGE_ERR=2, FALLBACK=3.
REQ-016 resp_tries  output  8  draws consumed for this result.

Function
REQ-017 FSM states IDLE, DRAW, RESP; req_ready SHALL be 1 only in IDLE with rst low.
REQ-018 Request accepted on req_valid && req_ready; req_lo/req_hi latched that cycle.
REQ-019 On accept: lo <= THRESH -> RESP, data 0, BELOW_THRESH, tries 0; else lo > hi -> RESP, data 0, RANGE_ERR, tries 0; else -> DRAW. BELOW_THRESH takes priority over RANGE_ERR.
REQ-020 Threshold/error paths: resp_valid SHALL assert the cycle after accept.
REQ-021 DRAW: span = hi-lo; mask = span with all bits below its MSB set; cand = lfsr[WIDTH-1:0] & mask.
REQ-022 LFSR (Galois, package polynomial) SHALL advance exactly once per DRAW cycle and never otherwise.
REQ-023 cand <= span -> accept: data = lo + cand (no overflow possible), OK, RESP.
REQ-024 MAX_TRIES consecutive rejects -> data = lo, FALLBACK, RESP.
REQ-025 resp_tries = number of DRAW cycles spent (1..MAX_TRIES).
REQ-026 lo == hi: mask 0, first draw accepts, data = lo, resp_valid 2 cycles after accept.
REQ-027 RESP: resp_valid, resp_data, resp_status, resp_tries held stable until resp_ready; on handshake -> IDLE, req_ready high next cycle.
REQ-028 req_valid ignored outside IDLE; back-to-back throughput at most one result per 2 cycles.

Reset
REQ-029 rst asserted SHALL immediately force: state IDLE, lfsr SEED, resp_valid 0, resp_data 0, resp_status 0, resp_tries 0, req_ready 0.
REQ-030 Reset mid-DRAW or mid-RESP SHALL discard the pending result; no response SHALL be produced for it.
REQ-031 First cycle after rst release: req_ready 1.

Configuration
REQ-032 Macro RANGE_RAND_GEN_ASSERT_EN defined: concurrent assertions compiled in -- resp_status OK/FALLBACK implies lo <= resp_data <= hi; RANGE_ERR/BELOW_THRESH implies resp_data 0; resp payload stable while resp_valid && !resp_ready; lfsr never 0; each failure reports via $error.
REQ-033 Macro undefined: no assertion code; functional behaviour identical.

Structure
REQ-034 Package range_rand_pkg SHALL hold the status enum, the FSM state enum, and per-LFSR_W tap constants (16: 16'hB400; 32: 32'h80200003).
REQ-035 Sub-module lfsr_galois (parameters WIDTH, TAPS, SEED; enable input; async reset) SHALL implement the generator.

Verification
REQ-036 lo=5, hi=255 -> resp_valid 1 cycle after accept, data 0, BELOW_THRESH, tries 0.
REQ-037 lo=200, hi=100 -> data 0, RANGE_ERR, LFSR state unchanged.
REQ-038 lo=hi=42 -> data 42, OK, tries 1, resp_valid 2 cycles after accept.
REQ-039 1000 random requests, lo=11, hi=255 -> every data in [11:255]; FALLBACK only with data 11; data sequence matches reference model of SEED 16'hACE1 LFSR.
REQ-040 resp_ready held low 5 cycles -> payload stable, req_ready 0 throughout; single result on release.
REQ-041 rst pulse during DRAW -> resp_valid 0, no stale result; next identical request sequence reproduces post-reset golden results exactly.
